// File: rtl/gen_mem_rd_sched.sv
// gen_mem_rd_sched: round-robin burst read scheduler for the read port of a simple
// dual-port memory. Accepted requests become bursts of consecutive-address reads.
// A tag pipeline matched to the memory read latency steers each returned word
// back to its owner together with a last-word flag.
module gen_mem_rd_sched #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WDT     = 10,
  parameter int DATA_WDT     = 32,
  parameter int LEN_WDT      = 8,
  parameter int PIPE_IN_CNT  = 1,
  parameter int PIPE_OUT_CNT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_vld,
  input  logic [NUM_REQ*ADDR_WDT-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WDT-1:0]  req_len,
  output logic [NUM_REQ-1:0]          req_rdy,
  output logic                        mem_rd_en,
  output logic [ADDR_WDT-1:0]         mem_rd_addr,
  input  logic [DATA_WDT-1:0]         mem_data_out,
  output logic [NUM_REQ-1:0]          rsp_vld,
  output logic [DATA_WDT-1:0]         rsp_data,
  output logic                        rsp_last,
  output logic                        busy
);

  // Cycles from a read issue to its word appearing on mem_data_out.
  localparam int RD_LAT = PIPE_IN_CNT + 1 + PIPE_OUT_CNT;
  localparam int ID_WDT = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so (last_grant + 1 + k) never overflows before the wrap.
  localparam int CW     = ID_WDT + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              state_reg;
  logic [ADDR_WDT-1:0] cur_addr_reg;
  logic [LEN_WDT-1:0]  cnt_reg;
  logic [ID_WDT-1:0]   owner_reg;
  logic [ID_WDT-1:0]   last_grant_reg;

  // Unpacked per-requester views of the packed request buses.
  logic [ADDR_WDT-1:0] addr_arr [NUM_REQ];
  logic [LEN_WDT-1:0]  len_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_WDT +: ADDR_WDT];
      assign len_arr[gi]  = req_len[gi*LEN_WDT +: LEN_WDT];
    end
  endgenerate

  // Round-robin search: first requesting index starting just after the last grant.
  // Walking the offsets from the far end lets the nearest candidate win last.
  logic              any_req;
  logic [ID_WDT-1:0] grant_id;
  logic [CW-1:0]     cand;

  always_comb begin
    any_req  = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = CW'(last_grant_reg) + CW'(k) + CW'(1);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (req_vld[cand[ID_WDT-1:0]]) begin
        any_req  = 1'b1;
        grant_id = cand[ID_WDT-1:0];
      end
    end
  end

  // A grant is only offered from IDLE; it is withheld while reset is being
  // applied so that no requester believes it was accepted into a dropped burst.
  logic accept;
  assign accept = (state_reg == ST_IDLE) && any_req && rst_n;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rdy
      assign req_rdy[gi] = accept && (grant_id == ID_WDT'(gi));
    end
  endgenerate

  // Burst FSM: capture the granted request in IDLE, then issue one read per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cur_addr_reg   <= '0;
      cnt_reg        <= '0;
      owner_reg      <= '0;
      last_grant_reg <= ID_WDT'(NUM_REQ - 1);
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg      <= ST_BURST;
            cur_addr_reg   <= addr_arr[grant_id];
            cnt_reg        <= len_arr[grant_id];
            owner_reg      <= grant_id;
            last_grant_reg <= grant_id;
          end
        end
        ST_BURST: begin
          cur_addr_reg <= cur_addr_reg + ADDR_WDT'(1);
          cnt_reg      <= cnt_reg - LEN_WDT'(1);
          if (cnt_reg == '0) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Reads are driven straight from registered state.
  assign mem_rd_en   = (state_reg == ST_BURST);
  assign mem_rd_addr = cur_addr_reg;

  // Tag pipeline, one stage per cycle of memory latency.
  logic [RD_LAT-1:0] tag_vld_reg;
  logic [RD_LAT-1:0] tag_last_reg;
  logic [ID_WDT-1:0] tag_id_reg [RD_LAT];

  // Shift {valid, owner, last} alongside the read as it travels through the memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld_reg  <= '0;
      tag_last_reg <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        tag_id_reg[s] <= '0;
      end
    end else begin
      tag_vld_reg[0]  <= mem_rd_en;
      tag_last_reg[0] <= mem_rd_en && (cnt_reg == '0);
      tag_id_reg[0]   <= owner_reg;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld_reg[s]  <= tag_vld_reg[s-1];
        tag_last_reg[s] <= tag_last_reg[s-1];
        tag_id_reg[s]   <= tag_id_reg[s-1];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_vld[gi] = tag_vld_reg[RD_LAT-1] && (tag_id_reg[RD_LAT-1] == ID_WDT'(gi));
    end
  endgenerate

  // The word on mem_data_out is aligned with the final tag stage, so it passes through.
  assign rsp_data = mem_data_out;
  assign rsp_last = tag_vld_reg[RD_LAT-1] && tag_last_reg[RD_LAT-1];
  assign busy     = (state_reg == ST_BURST) || (|tag_vld_reg);

`ifndef SYNTHESIS
  logic [NUM_REQ-1:0]          pend_reg;
  logic [NUM_REQ*ADDR_WDT-1:0] prev_addr_reg;
  logic [NUM_REQ*LEN_WDT-1:0]  prev_len_reg;

  // Requester protocol and one-hot output checks, simulation only.
  always_ff @(posedge clk) begin
    pend_reg      <= rst_n ? (req_vld & ~req_rdy) : '0;
    prev_addr_reg <= req_addr;
    prev_len_reg  <= req_len;
    if (rst_n) begin
      assert ($onehot0(req_rdy));
      assert ($onehot0(rsp_vld));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pend_reg[i] && req_vld[i]) begin
          assert (req_addr[i*ADDR_WDT +: ADDR_WDT] == prev_addr_reg[i*ADDR_WDT +: ADDR_WDT]);
          assert (req_len[i*LEN_WDT +: LEN_WDT] == prev_len_reg[i*LEN_WDT +: LEN_WDT]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_gen_mem_rd_sched.sv
// Bench for gen_mem_rd_sched: directed table of single bursts, hand sequences for
// round-robin, fairness and mid-burst reset, then random traffic checked every
// cycle against a queue-based reference model. Memory model: mem[a] = a, RD_LAT = 3.
module tb_gen_mem_rd_sched;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 8;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_vld;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*LW-1:0]  req_len;
  logic [NR-1:0]     req_rdy;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [DW-1:0]     mem_data_out;
  logic [NR-1:0]     rsp_vld;
  logic [DW-1:0]     rsp_data;
  logic              rsp_last;
  logic              busy;

  gen_mem_rd_sched #(
    .NUM_REQ(NR), .ADDR_WDT(AW), .DATA_WDT(DW), .LEN_WDT(LW),
    .PIPE_IN_CNT(1), .PIPE_OUT_CNT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_addr(req_addr), .req_len(req_len),
    .req_rdy(req_rdy), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_data_out(mem_data_out), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory read port model: three-cycle latency, contents mem[a] = a.
  logic [AW-1:0] mp0 = '0, mp1 = '0, mp2 = '0;
  always @(posedge clk) begin
    mp0 <= mem_rd_addr;
    mp1 <= mp0;
    mp2 <= mp1;
  end
  assign mem_data_out = {{(DW-AW){1'b0}}, mp2};

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Abstract view: a queue of reads still to be issued (one per cycle) and a
  // queue of words due back at issue+3. New bursts are accepted only when
  // nothing is left to issue; the search pointer starts after the last grant.
  typedef struct { int id; logic [AW-1:0] addr; logic last; } iss_t;
  typedef struct { int due; int id; logic [AW-1:0] addr; logic last; } rsp_t;
  typedef struct { int cyc; logic [NR-1:0] oh; logic [AW-1:0] addr; logic [DW-1:0] data; logic last; } log_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   ptr = 0;
  log_t grant_log[$];
  log_t issue_log[$];
  log_t rsp_log[$];
  int   busy_fall_cyc = -1;
  logic prev_busy = 1'b0;

  logic [NR-1:0] m_exp_rdy;
  int            m_g;
  logic          m_exp_busy;
  iss_t          m_it;
  rsp_t          m_rt;
  log_t          m_lg;
  logic [AW-1:0] m_base;
  int            m_n;

  always @(negedge clk) begin
    if (!rst_n) begin
      iss_q.delete();
      rsp_q.delete();
      ptr       = 0;
      prev_busy = 1'b0;
    end else begin
      m_exp_busy = (iss_q.size() > 0) || (rsp_q.size() > 0);
      m_exp_rdy  = '0;
      m_g        = -1;
      if (iss_q.size() == 0) begin
        for (int k = 0; k < NR; k++) begin
          if (m_g < 0 && req_vld[(ptr + k) % NR]) m_g = (ptr + k) % NR;
        end
        if (m_g >= 0) m_exp_rdy[m_g] = 1'b1;
      end
      chk("req_rdy", req_rdy, m_exp_rdy);
      chk("mem_rd_en", mem_rd_en, iss_q.size() > 0);
      if (iss_q.size() > 0) begin
        m_it = iss_q.pop_front();
        chk("mem_rd_addr", mem_rd_addr, m_it.addr);
        rsp_q.push_back('{cyc + 3, m_it.id, m_it.addr, m_it.last});
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        m_rt = rsp_q.pop_front();
        chk("rsp_vld", rsp_vld, 64'(1) << m_rt.id);
        chk("rsp_data", rsp_data, {{(DW-AW){1'b0}}, m_rt.addr});
        chk("rsp_last", rsp_last, m_rt.last);
      end else begin
        chk("rsp_vld_idle", rsp_vld, 0);
        chk("rsp_last_idle", rsp_last, 0);
      end
      chk("busy", busy, m_exp_busy);

      // Observation logs for the directed sequences.
      m_lg = '{cyc, req_rdy, mem_rd_addr, rsp_data, rsp_last};
      if (req_rdy != 0) grant_log.push_back(m_lg);
      if (mem_rd_en) issue_log.push_back('{cyc, rsp_vld, mem_rd_addr, rsp_data, rsp_last});
      m_lg.oh = rsp_vld;
      if (rsp_vld != 0) rsp_log.push_back(m_lg);
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;

      if (m_g >= 0) begin
        m_base = req_addr[m_g*AW +: AW];
        m_n    = int'(req_len[m_g*LW +: LW]) + 1;
        for (int j = 0; j < m_n; j++) begin
          iss_q.push_back('{m_g, m_base + AW'(j), (j == m_n - 1)});
        end
        ptr = (m_g + 1) % NR;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    grant_log.delete();
    issue_log.delete();
    rsp_log.delete();
    busy_fall_cyc = -1;
  endtask

  task automatic set_req(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[id*AW +: AW] = a;
    req_len[id*LW +: LW]  = l;
    req_vld[id]           = 1'b1;
  endtask

  // Run until ngrants acceptances are seen; drop requesters in drop_mask on grant.
  task automatic serve(input logic [NR-1:0] drop_mask, input int ngrants);
    logic [NR-1:0] rdy_s;
    int got = 0;
    for (int t = 0; t < 600 && got < ngrants; t++) begin
      @(negedge clk);
      rdy_s = req_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (rdy_s[i]) begin
          got++;
          if (drop_mask[i]) req_vld[i] = 1'b0;
        end
      end
    end
    chk("serve_grants", got, ngrants);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 2000);
    chk("idle_reached", busy, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [NR-1:0] exp_rdy;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t          tv [5];
  logic [NR-1:0] seq_rr [4];
  logic [NR-1:0] seq_fair [4];
  int            n_last;
  int            g0;
  int            grants_seen [NR];
  logic [NR-1:0] rdy_r;

  initial begin
    // Table entries are single isolated bursts; the last one uses requester 3.
    tv[0] = '{0, 10'h010, 8'd3,  4'b0001, 10'h010, 10'h013};
    tv[1] = '{1, 10'h3FE, 8'd3,  4'b0010, 10'h3FE, 10'h001};
    tv[2] = '{2, 10'h155, 8'd0,  4'b0100, 10'h155, 10'h155};
    tv[3] = '{0, 10'h3F0, 8'd31, 4'b0001, 10'h3F0, 10'h00F};
    tv[4] = '{3, 10'h3FF, 8'd1,  4'b1000, 10'h3FF, 10'h000};
    seq_rr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq_fair = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    rst_n    = 1'b0;
    req_vld  = '0;
    req_addr = '0;
    req_len  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;

    // Round-robin right after reset: all four, length 1 word each.
    clear_logs();
    for (int i = 0; i < NR; i++) set_req(i, AW'(10'h200 + 16 * i), 8'd0);
    serve(4'b1111, 4);
    wait_idle();
    chk("rr_ngrants", grant_log.size(), 4);
    chk("rr_nrsp", rsp_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) begin
        chk("rr_grant_oh", grant_log[i].oh, seq_rr[i]);
        if (i > 0) chk("rr_grant_gap", grant_log[i].cyc - grant_log[i-1].cyc, 2);
      end
      if (i < rsp_log.size()) begin
        chk("rr_rsp_oh", rsp_log[i].oh, seq_rr[i]);
        chk("rr_rsp_data", rsp_log[i].data, 32'h200 + 32'(16 * i));
      end
    end

    // Table of single bursts.
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      clear_logs();
      set_req(tv[v].id, tv[v].addr, tv[v].len);
      serve(4'b1111, 1);
      wait_idle();
      chk("tbl_ngrants", grant_log.size(), 1);
      chk("tbl_nissue", issue_log.size(), int'(tv[v].len) + 1);
      chk("tbl_nrsp", rsp_log.size(), int'(tv[v].len) + 1);
      if (grant_log.size() > 0 && issue_log.size() > 0 && rsp_log.size() > 0) begin
        g0 = grant_log[0].cyc;
        chk("tbl_rdy", grant_log[0].oh, tv[v].exp_rdy);
        chk("tbl_first_addr", issue_log[0].addr, tv[v].exp_first);
        chk("tbl_last_addr", issue_log[issue_log.size()-1].addr, tv[v].exp_last);
        chk("tbl_issue_start", issue_log[0].cyc - g0, 1);
        chk("tbl_issue_end", issue_log[issue_log.size()-1].cyc - g0, int'(tv[v].len) + 1);
        chk("tbl_rsp_owner", rsp_log[0].oh, tv[v].exp_rdy);
        chk("tbl_rsp_first", rsp_log[0].cyc - g0, 4);
        chk("tbl_rsp_end", rsp_log[rsp_log.size()-1].cyc - g0, int'(tv[v].len) + 4);
        chk("tbl_rsp_last_data", rsp_log[rsp_log.size()-1].data, {{(DW-AW){1'b0}}, tv[v].exp_last});
        chk("tbl_rsp_last_flag", rsp_log[rsp_log.size()-1].last, 1);
        n_last = 0;
        foreach (rsp_log[j]) if (rsp_log[j].last) n_last++;
        chk("tbl_nlast", n_last, 1);
        chk("tbl_busy_fall", busy_fall_cyc - g0, int'(tv[v].len) + 5);
      end
    end

    // Fairness: requesters 0 and 2 held continuously, two-word bursts.
    wait_idle();
    clear_logs();
    set_req(0, 10'h080, 8'd1);
    set_req(2, 10'h0C0, 8'd1);
    serve(4'b0000, 4);
    req_vld = '0;
    wait_idle();
    chk("fair_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) begin
        chk("fair_grant_oh", grant_log[i].oh, seq_fair[i]);
        if (i > 0) chk("fair_grant_gap", grant_log[i].cyc - grant_log[i-1].cyc, 3);
      end
    end

    // Reset in the middle of an 8-word burst from requester 3.
    wait_idle();
    set_req(3, 10'h040, 8'd7);
    rdy_r = '0;
    for (int t = 0; t < 50 && !rdy_r[3]; t++) begin
      @(negedge clk);
      rdy_r = req_rdy;
    end
    chk("rstb_accept", rdy_r[3], 1);
    @(posedge clk); #1;                 // first read
    set_req(0, 10'h300, 8'd0);
    @(posedge clk); #1;                 // second read
    @(posedge clk); #1;                 // third read, reset asserted
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstb_third_en", mem_rd_en, 1);
    chk("rstb_third_addr", mem_rd_addr, 10'h042);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstb_after_en", mem_rd_en, 0);
    chk("rstb_after_rsp", rsp_vld, 0);
    chk("rstb_after_busy", busy, 0);
    chk("rstb_after_grant", req_rdy, 4'b0001);
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstb_no_late_rsp", rsp_vld, 0);
      @(posedge clk); #1;
    end
    serve(4'b1000, 1);
    wait_idle();

    // Random traffic against the model.
    for (int i = 0; i < NR; i++) grants_seen[i] = 0;
    for (int t = 0; t < 10000; t++) begin
      @(negedge clk);
      rdy_r = req_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (rdy_r[i]) grants_seen[i]++;
        if (rdy_r[i] || !req_vld[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_req(i, AW'($urandom_range(0, 1023)),
                    ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 63)) : LW'($urandom_range(0, 5)));
          end else begin
            req_vld[i] = 1'b0;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req_vld[i] = 1'b0;        // withdraw before being granted
        end
      end
    end
    req_vld = '0;
    wait_idle();
    chk("rand_drain_issue", iss_q.size(), 0);
    chk("rand_drain_rsp", rsp_q.size(), 0);
    for (int i = 0; i < NR; i++) chk("rand_req_served", grants_seen[i] > 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
